mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 56 +++++
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the arbiter and the
// single-port memory. The arbiter connects through the slave modport;
// the core/memory side connects through the master modport.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // Instruction-fetch port
  logic              iIReq;
  logic [ADDR_W-1:0] iIAddress;
  logic [DATA_W-1:0] oIReadData;
  logic              oIAck;

  // Data port
  logic              iDReq;
  logic              iDWrite;
  logic [ADDR_W-1:0] iDAddress;
  logic [DATA_W-1:0] iDWriteData;
  logic [3:0]        iDByteEnable;
  logic [DATA_W-1:0] oDReadData;
  logic              oDAck;

  // Memory side
  logic [ADDR_W-1:0] oMemAddress;
  logic [DATA_W-1:0] oMemWriteData;
  logic [3:0]        oMemByteEnable;
  logic              oMemRead;
  logic              oMemWrite;
  logic [DATA_W-1:0] iMemReadData;

  // Debug
  logic [1:0]        oGrant;
  logic [2:0]        oState;

  modport slave (
    input  iIReq, iIAddress,
    input  iDReq, iDWrite, iDAddress, iDWriteData, iDByteEnable,
    input  iMemReadData,
    output oIReadData, oIAck,
    output oDReadData, oDAck,
    output oMemAddress, oMemWriteData, oMemByteEnable, oMemRead, oMemWrite,
    output oGrant, oState
  );

  modport master (
    output iIReq, iIAddress,
    output iDReq, iDWrite, iDAddress, iDWriteData, iDByteEnable,
    output iMemReadData,
    input  oIReadData, oIAck,
    input  oDReadData, oDAck,
    input  oMemAddress, oMemWriteData, oMemByteEnable, oMemRead, oMemWrite,
    input  oGrant, oState
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch port and the
// data port. Each access runs IDLE -> CMD -> (WAIT) -> ACK with no
// pipelining. Data accesses win arbitration unless the fetch port has
// already been passed over STARVE_LIMIT times in a row.
// Reads spend MEM_LATENCY cycles in WAIT; the read data is captured at the
// end of the last WAIT cycle so it is already valid while the ack is high.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic                iCLOCK,
  input logic                iRST_n,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    WAIT = 3'd2,
    ACK  = 3'd3
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [3:0] STARVE_SAT = 4'hF;
  localparam logic [1:0] LAT_LAST   = 2'(MEM_LATENCY - 1);

  state_t            state;
  state_t            next_state;
  logic [3:0]        starve;
  logic [1:0]        lat_cnt;
  logic [1:0]        grant;
  logic              is_write;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [3:0]        be_r;
  logic [DATA_W-1:0] i_rdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_win;
  logic              i_win;
  logic              lat_done;

  // Arbitration: data first, unless the fetch port has waited too long
  always_comb begin
    d_win    = 1'b0;
    i_win    = 1'b0;
    lat_done = (lat_cnt == LAT_LAST);
    if (bus.iDReq && (!bus.iIReq || (starve < STARVE_MAX))) begin
      d_win = 1'b1;
    end else if (bus.iIReq) begin
      i_win = 1'b1;
    end
  end

  // State register
  always_ff @(posedge iCLOCK) begin
    if (!iRST_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; writes skip WAIT because nothing comes back
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (d_win || i_win) begin
          next_state = CMD;
        end
      end
      CMD: begin
        if (is_write) begin
          next_state = ACK;
        end else begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (lat_done) begin
          next_state = ACK;
        end
      end
      ACK: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request registration at grant, latency counting and read-data capture
  always_ff @(posedge iCLOCK) begin
    if (!iRST_n) begin
      grant    <= GRANT_NONE;
      is_write <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= '0;
      be_r     <= 4'h0;
      lat_cnt  <= 2'd0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_win) begin
            grant    <= GRANT_D;
            addr_r   <= bus.iDAddress;
            wdata_r  <= bus.iDWriteData;
            be_r     <= bus.iDByteEnable;
            is_write <= bus.iDWrite;
          end else if (i_win) begin
            grant    <= GRANT_I;
            addr_r   <= bus.iIAddress;
            be_r     <= 4'hF;
            is_write <= 1'b0;
          end
        end
        CMD: begin
          lat_cnt <= 2'd0;
        end
        WAIT: begin
          if (lat_done) begin
            if (grant == GRANT_I) begin
              i_rdata <= bus.iMemReadData;
            end else begin
              d_rdata <= bus.iMemReadData;
            end
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        ACK: begin
          grant <= GRANT_NONE;
        end
        default: begin
          grant <= GRANT_NONE;
        end
      endcase
    end
  end

  // Starvation counter: counts data grants made over a waiting fetch
  always_ff @(posedge iCLOCK) begin
    if (!iRST_n) begin
      starve <= 4'd0;
    end else if (state == IDLE) begin
      if (!bus.iIReq || i_win) begin
        starve <= 4'd0;
      end else if (d_win && (starve != STARVE_SAT)) begin
        starve <= starve + 4'd1;
      end
    end
  end

  assign bus.oMemAddress    = addr_r;
  assign bus.oMemWriteData  = wdata_r;
  assign bus.oMemByteEnable = be_r;
  assign bus.oMemRead       = (state == CMD) && !is_write;
  assign bus.oMemWrite      = (state == CMD) && is_write;
  assign bus.oIReadData     = i_rdata;
  assign bus.oDReadData     = d_rdata;
  assign bus.oIAck          = (state == ACK) && (grant == GRANT_I);
  assign bus.oDAck          = (state == ACK) && (grant == GRANT_D);
  assign bus.oGrant         = grant;
  assign bus.oState         = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. bus1 drives an instance with
// MEM_LATENCY=1, bus3 an instance with MEM_LATENCY=3. Inputs are driven and
// outputs sampled 2 time units after each rising edge.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dut1 (
    .iCLOCK (clk),
    .iRST_n (rst_n),
    .bus    (bus1.slave)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
    .iCLOCK (clk),
    .iRST_n (rst_n),
    .bus    (bus3.slave)
  );

  // Compare one observed value against its expected value and tally it
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Advance one cycle and settle past the edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Put every requester/memory input of both buses in a quiet state
  task automatic applyStimulus();
    bus1.iIReq = 1'b0; bus1.iIAddress = '0;
    bus1.iDReq = 1'b0; bus1.iDWrite = 1'b0; bus1.iDAddress = '0;
    bus1.iDWriteData = '0; bus1.iDByteEnable = 4'h0; bus1.iMemReadData = '0;
    bus3.iIReq = 1'b0; bus3.iIAddress = '0;
    bus3.iDReq = 1'b0; bus3.iDWrite = 1'b0; bus3.iDAddress = '0;
    bus3.iDWriteData = '0; bus3.iDByteEnable = 4'h0; bus3.iMemReadData = '0;
  endtask

  logic [1:0] exp_grant [10];

  initial begin
    int n;
    int cyc;
    exp_grant = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

    applyStimulus();
    rst_n = 1'b0;
    tick(); tick(); tick();
    checkOutput("rst_state", bus1.oState, 3'd0);
    checkOutput("rst_grant", bus1.oGrant, 2'b00);
    checkOutput("rst_iread", bus1.oIReadData, 32'h0);
    checkOutput("rst_dread", bus1.oDReadData, 32'h0);
    checkOutput("rst_memaddr", bus1.oMemAddress, 32'h0);
    rst_n = 1'b1;
    tick();
    checkOutput("idle_no_req_state", bus1.oState, 3'd0);
    checkOutput("idle_no_req_grant", bus1.oGrant, 2'b00);

    // Reset in the middle of a pending read
    bus1.iIReq = 1'b1; bus1.iIAddress = 32'h0040_0000;
    tick();
    checkOutput("abort_cmd_read", bus1.oMemRead, 1'b1);
    rst_n = 1'b0;
    tick();
    checkOutput("abort_state", bus1.oState, 3'd0);
    checkOutput("abort_grant", bus1.oGrant, 2'b00);
    checkOutput("abort_memread", bus1.oMemRead, 1'b0);
    checkOutput("abort_memaddr", bus1.oMemAddress, 32'h0);
    bus1.iIReq = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("abort_no_iack_%0d", i), bus1.oIAck, 1'b0);
    end

    // Single fetch, MEM_LATENCY=1
    bus1.iIReq = 1'b1; bus1.iIAddress = 32'h0040_0000;
    bus1.iMemReadData = 32'hAAAA_AAAA;
    tick();
    checkOutput("fetch_state_cmd", bus1.oState, 3'd1);
    checkOutput("fetch_memread", bus1.oMemRead, 1'b1);
    checkOutput("fetch_memaddr", bus1.oMemAddress, 32'h0040_0000);
    checkOutput("fetch_be", bus1.oMemByteEnable, 4'hF);
    checkOutput("fetch_grant", bus1.oGrant, 2'b01);
    tick();
    bus1.iMemReadData = 32'h0050_0093;
    checkOutput("fetch_state_wait", bus1.oState, 3'd2);
    checkOutput("fetch_memread_low", bus1.oMemRead, 1'b0);
    checkOutput("fetch_no_early_ack", bus1.oIAck, 1'b0);
    tick();
    bus1.iMemReadData = 32'h5555_5555;
    checkOutput("fetch_iack", bus1.oIAck, 1'b1);
    checkOutput("fetch_dack_quiet", bus1.oDAck, 1'b0);
    checkOutput("fetch_rdata", bus1.oIReadData, 32'h0050_0093);
    bus1.iIReq = 1'b0;
    tick();
    checkOutput("fetch_back_idle", bus1.oState, 3'd0);
    checkOutput("fetch_ack_pulse", bus1.oIAck, 1'b0);
    checkOutput("fetch_rdata_hold", bus1.oIReadData, 32'h0050_0093);

    // Data write; fields change after the grant and must be ignored
    bus1.iDReq = 1'b1; bus1.iDWrite = 1'b1; bus1.iDAddress = 32'h1001_0000;
    bus1.iDWriteData = 32'hDEAD_BEEF; bus1.iDByteEnable = 4'b0011;
    tick();
    bus1.iDWriteData = 32'h0; bus1.iDAddress = 32'h0; bus1.iDByteEnable = 4'hF;
    checkOutput("write_memwrite", bus1.oMemWrite, 1'b1);
    checkOutput("write_memread", bus1.oMemRead, 1'b0);
    checkOutput("write_addr", bus1.oMemAddress, 32'h1001_0000);
    checkOutput("write_data", bus1.oMemWriteData, 32'hDEAD_BEEF);
    checkOutput("write_be", bus1.oMemByteEnable, 4'b0011);
    checkOutput("write_grant", bus1.oGrant, 2'b10);
    tick();
    checkOutput("write_dack", bus1.oDAck, 1'b1);
    checkOutput("write_strobe_low", bus1.oMemWrite, 1'b0);
    checkOutput("write_iread_kept", bus1.oIReadData, 32'h0050_0093);
    bus1.iDReq = 1'b0; bus1.iDWrite = 1'b0;
    tick();
    checkOutput("write_back_idle", bus1.oState, 3'd0);

    // Contention: both requests held high, grant order shows starvation relief
    bus1.iIAddress = 32'h0040_0020; bus1.iDAddress = 32'h1001_0008; bus1.iDWrite = 1'b0;
    bus1.iMemReadData = 32'h1111_2222;
    bus1.iIReq = 1'b1; bus1.iDReq = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 10 && cyc < 200) begin
      tick();
      cyc++;
      if (bus1.oState == 3'd1) begin
        checkOutput($sformatf("grant_order_%0d", n), bus1.oGrant, exp_grant[n]);
        n++;
      end
    end
    if (n < 10) checkOutput("contention_timeout", n, 10);
    bus1.iIReq = 1'b0; bus1.iDReq = 1'b0;
    tick(); tick(); tick();
    checkOutput("contention_idle", bus1.oState, 3'd0);
    checkOutput("contention_iread", bus1.oIReadData, 32'h1111_2222);

    // Data read with the request dropped right after the grant
    bus1.iDReq = 1'b1; bus1.iDWrite = 1'b0; bus1.iDAddress = 32'h1001_0004;
    bus1.iMemReadData = 32'h7777_7777;
    tick();
    bus1.iDReq = 1'b0;
    checkOutput("drop_memread", bus1.oMemRead, 1'b1);
    checkOutput("drop_addr", bus1.oMemAddress, 32'h1001_0004);
    tick();
    bus1.iMemReadData = 32'hCAFE_F00D;
    tick();
    bus1.iMemReadData = 32'h0;
    checkOutput("drop_dack", bus1.oDAck, 1'b1);
    checkOutput("drop_rdata", bus1.oDReadData, 32'hCAFE_F00D);
    tick();
    checkOutput("drop_idle", bus1.oState, 3'd0);
    checkOutput("drop_dack_low", bus1.oDAck, 1'b0);
    checkOutput("drop_iread_kept", bus1.oIReadData, 32'h1111_2222);

    // MEM_LATENCY=3 fetch: only the c+3 value may be captured
    bus3.iIReq = 1'b1; bus3.iIAddress = 32'h0040_0010;
    tick();
    bus3.iMemReadData = 32'hBAD0_0000;
    checkOutput("l3_memread", bus3.oMemRead, 1'b1);
    tick();
    bus3.iMemReadData = 32'hBAD0_0001;
    checkOutput("l3_wait1", bus3.oState, 3'd2);
    tick();
    bus3.iMemReadData = 32'hBAD0_0002;
    checkOutput("l3_wait2", bus3.oState, 3'd2);
    tick();
    bus3.iMemReadData = 32'h1234_5678;
    checkOutput("l3_wait3", bus3.oState, 3'd2);
    checkOutput("l3_no_early_ack", bus3.oIAck, 1'b0);
    tick();
    bus3.iMemReadData = 32'hBAD0_0004;
    checkOutput("l3_iack", bus3.oIAck, 1'b1);
    checkOutput("l3_rdata", bus3.oIReadData, 32'h1234_5678);
    bus3.iIReq = 1'b0;
    tick();
    checkOutput("l3_idle", bus3.oState, 3'd0);
    checkOutput("l3_rdata_hold", bus3.oIReadData, 32'h1234_5678);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
